// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 8-bit CPU.
// Owns pc, ir and the zero flag; drives ALU opcode, operand and strobes.
//
// Ports:
//   clk        in  rising-edge clock
//   reset      in  asynchronous active-high reset, clears all state
//   start      in  level; leaves IDLE when high
//   instr_in   in  instruction word for the current pc
//   mem_ready  in  instr_in valid; only looked at in FETCH
//   alu_zero   in  ALU result is zero; sampled in WRITEBACK
//   pc         out fetch address
//   mem_rd     out fetch request, high every FETCH cycle
//   alu_op     out ir[7:4] for opcodes 1..7, else 0
//   imm_out    out zero-extended operand ir[3:0]
//   reg_a_save out one-cycle save strobe for register A
//   reg_b_save out one-cycle save strobe for register B
//   reg_clr    out one-cycle register clear strobe
//   busy       out high in FETCH/DECODE/EXECUTE/WRITEBACK
//   halted     out high in HALT
//   illegal    out one-cycle pulse in EXECUTE for opcodes B..E
module cpu_sequencer #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              mem_ready,
    input  logic              alu_zero,
    output logic [PC_W-1:0]   pc,
    output logic              mem_rd,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] imm_out,
    output logic              reg_a_save,
    output logic              reg_b_save,
    output logic              reg_clr,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    localparam int IMM_W = DATA_W - OP_W;

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_LDB = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_CLR = OP_W'(4'hA);
    localparam logic [OP_W-1:0] OP_IL0 = OP_W'(4'hB);
    localparam logic [OP_W-1:0] OP_IL1 = OP_W'(4'hE);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] ir, ir_n;
    logic [PC_W-1:0]   pc_n;
    logic              z_flag, z_n;

    logic [OP_W-1:0]   op;
    logic [IMM_W-1:0]  imm;
    logic              is_alu;
    logic              is_ill;
    logic              jz_taken;

    assign op       = ir[DATA_W-1:IMM_W];
    assign imm      = ir[IMM_W-1:0];
    assign is_alu   = (op >= OP_LDA) && (op <= OP_XOR);
    assign is_ill   = (op >= OP_IL0) && (op <= OP_IL1);
    assign jz_taken = (op == OP_JZ) && z_flag;

    // ir only changes in FETCH, so these hold from DECODE to WRITEBACK.
    assign alu_op  = is_alu ? op : '0;
    assign imm_out = {{OP_W{1'b0}}, imm};

    assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_EXECUTE) || (state == S_WRITEBACK);
    assign halted = (state == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            z_flag <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            ir     <= ir_n;
            z_flag <= z_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        z_n        = z_flag;
        mem_rd     = 1'b0;
        reg_a_save = 1'b0;
        reg_b_save = 1'b0;
        reg_clr    = 1'b0;
        illegal    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_n    = instr_in;
                    pc_n    = pc + PC_W'(1);
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                state_n = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_n = S_FETCH;
                if (is_alu) begin
                    state_n = S_WRITEBACK;
                end else if (op == OP_HLT) begin
                    state_n = S_HALT;
                end else if ((op == OP_JMP) || jz_taken) begin
                    pc_n = PC_W'(imm);
                end else if (op == OP_CLR) begin
                    reg_clr = 1'b1;
                    z_n     = 1'b1;
                end else if (is_ill) begin
                    illegal = 1'b1;
                end
            end
            S_WRITEBACK: begin
                state_n = S_FETCH;
                if (op == OP_LDB) reg_b_save = 1'b1;
                else              reg_a_save = 1'b1;
                // Loads leave the flag; only real ALU results update it.
                if (op >= OP_ADD) z_n = alu_zero;
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and random checks of cpu_sequencer against
// an instruction-level reference model.
module tb_cpu_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] instr_in;
    logic       mem_ready;
    logic       alu_zero;
    logic [7:0] pc;
    logic       mem_rd;
    logic [3:0] alu_op;
    logic [7:0] imm_out;
    logic       reg_a_save;
    logic       reg_b_save;
    logic       reg_clr;
    logic       busy;
    logic       halted;
    logic       illegal;

    logic [7:0] mem [256];

    int npass;
    int ntot;

    logic [7:0] pc_m;
    logic [7:0] ir_m;
    logic       z_m;

    cpu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr_in   (instr_in),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .mem_rd     (mem_rd),
        .alu_op     (alu_op),
        .imm_out    (imm_out),
        .reg_a_save (reg_a_save),
        .reg_b_save (reg_b_save),
        .reg_clr    (reg_clr),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal)
    );

    assign instr_in = mem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return 32'({mem_rd, reg_a_save, reg_b_save, reg_clr,
                    illegal, busy, halted});
    endfunction

    function automatic logic [31:0] ectl(input logic mr, input logic a,
                                         input logic b, input logic clr,
                                         input logic ill, input logic bsy,
                                         input logic hlt);
        return 32'({mr, a, b, clr, ill, bsy, hlt});
    endfunction

    function automatic logic [3:0] exp_alu(input logic [3:0] op);
        return (op >= 4'h1 && op <= 4'h7) ? op : 4'h0;
    endfunction

    function automatic logic [31:0] eir(input logic [7:0] ins);
        return 32'({exp_alu(ins[7:4]), 4'h0, ins[3:0]});
    endfunction

    function automatic logic [31:0] oir();
        return 32'({alu_op, imm_out});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset taken between clock edges, checked before any edge.
    task automatic do_reset();
        start = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ctl", ctl(), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", oir(), 32'h0);
        pc_m = 8'h00;
        ir_m = 8'h00;
        z_m  = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        chk("idle_ctl", ctl(), 32'h0);
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
    endtask

    // One instruction from its first FETCH cycle to the next FETCH (or HALT).
    task automatic step_instr(input int stall, input logic az,
                              output logic [3:0] op_o);
        logic [7:0] ins;
        logic [3:0] op;
        logic       alu;
        for (int i = 0; i <= stall; i++) begin
            mem_ready = (i == stall);
            start     = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            chk("fetch_ctl", ctl(), ectl(1, 0, 0, 0, 0, 1, 0));
            chk("fetch_pc", 32'(pc), 32'(pc_m));
            chk("fetch_ir", oir(), eir(ir_m));
            tick();
        end
        mem_ready = 1'($urandom_range(0, 1));
        ins  = mem[pc_m];
        ir_m = ins;
        op   = ins[7:4];
        alu  = (op >= 4'h1 && op <= 4'h7);
        pc_m = pc_m + 8'h01;
        chk("dec_ctl", ctl(), ectl(0, 0, 0, 0, 0, 1, 0));
        chk("dec_ir", oir(), eir(ins));
        chk("dec_pc", 32'(pc), 32'(pc_m));
        tick();
        chk("exe_ctl", ctl(),
            ectl(0, 0, 0, op == 4'hA, op >= 4'hB && op <= 4'hE, 1, 0));
        chk("exe_ir", oir(), eir(ins));
        tick();
        if (op == 4'h8 || (op == 4'h9 && z_m)) pc_m = {4'h0, ins[3:0]};
        if (op == 4'hA) z_m = 1'b1;
        if (alu) begin
            alu_zero = az;
            chk("wb_ctl", ctl(), ectl(0, op != 4'h2, op == 4'h2, 0, 0, 1, 0));
            chk("wb_ir", oir(), eir(ins));
            tick();
            if (op >= 4'h3) z_m = az;
        end
        if (op == 4'hF) begin
            chk("halt_ctl", ctl(), ectl(0, 0, 0, 0, 0, 0, 1));
            chk("halt_pc", 32'(pc), 32'(pc_m));
        end
        op_o = op;
    endtask

    initial begin
        logic [3:0] op;
        logic [3:0] o;
        npass     = 0;
        ntot      = 0;
        reset     = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        #1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_hold", ctl(), 32'h0);
        end

        // Four-instruction program, cycle-exact strobe timing.
        mem[0] = 8'h13;
        mem[1] = 8'h22;
        mem[2] = 8'h30;
        mem[3] = 8'hF0;
        start     = 1'b1;
        mem_ready = 1'b1;
        alu_zero  = 1'b0;
        tick();
        for (int c = 1; c <= 16; c++) begin
            chk("p_a", 32'(reg_a_save), 32'(c == 4 || c == 12));
            chk("p_b", 32'(reg_b_save), 32'(c == 8));
            chk("p_h", 32'(halted), 32'(c == 16));
            if (c == 12) chk("p_op", 32'(alu_op), 32'h3);
            if (c < 16) tick();
        end
        chk("p_pc", 32'(pc), 32'h4);

        // HALT is sticky even with start held.
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hlt_ctl", ctl(), ectl(0, 0, 0, 0, 0, 0, 1));
            chk("hlt_pc", 32'(pc), 32'h4);
        end
        do_reset();

        // Reset while stalled in FETCH at pc=5.
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        launch();
        for (int i = 0; i < 5; i++) step_instr(0, 1'b0, op);
        mem_ready = 1'b0;
        chk("mid_pc", 32'(pc), 32'h5);
        chk("mid_ctl", ctl(), ectl(1, 0, 0, 0, 0, 1, 0));
        do_reset();

        // Five-cycle fetch stall after a load.
        mem[0] = 8'h13;
        mem[1] = 8'h2A;
        mem[2] = 8'hF0;
        launch();
        step_instr(0, 1'b0, op);
        step_instr(5, 1'b0, op);
        step_instr(1, 1'b0, op);
        do_reset();

        // JZ taken after a zero SUB, then untaken after a nonzero SUB.
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        mem[0] = 8'h13;
        mem[1] = 8'h40;
        mem[2] = 8'h97;
        launch();
        step_instr(0, 1'b0, op);
        step_instr(0, 1'b1, op);
        step_instr(0, 1'b0, op);
        chk("jz_taken", 32'(pc), 32'h7);
        step_instr(0, 1'b0, op);
        do_reset();
        launch();
        step_instr(0, 1'b0, op);
        step_instr(0, 1'b0, op);
        step_instr(0, 1'b0, op);
        chk("jz_untaken", 32'(pc), 32'h3);
        do_reset();

        // pc wrap 0xFF -> 0x00, illegal opcode at 0x00.
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'hB0;
        launch();
        for (int i = 0; i < 256; i++) step_instr(0, 1'b0, op);
        chk("wrap_pc", 32'(pc), 32'h0);
        step_instr(0, 1'b0, op);
        chk("wrap_op", 32'(op), 32'hB);
        do_reset();

        // Random programs with random stalls and ALU zero results.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) begin
                o = ($urandom_range(0, 99) < 4) ? 4'hF
                                                : 4'($urandom_range(0, 14));
                mem[i] = {o, 4'($urandom_range(0, 15))};
            end
            launch();
            for (int n = 0; n < 150; n++) begin
                step_instr($urandom_range(0, 3), 1'($urandom_range(0, 1)), op);
                if (op == 4'hF) break;
            end
            if (op == 4'hF) begin
                start = 1'b1;
                tick();
                chk("rnd_halt", ctl(), ectl(0, 0, 0, 0, 0, 0, 1));
                chk("rnd_hpc", 32'(pc), 32'(pc_m));
            end
            do_reset();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
